sequence_generator_serial: RTL and testbench

Serial pattern transmitter that drives the single-bit `x` stream consumed by the sequence detectors, such as the Moore "101" detector. It takes a programmable pattern of up to `WIDTH` bits, shifts it out MSB-first one bit per clock, and repeats it a programmable number of times. It replaces hand-written `x` stimulus with a reusable, self-timed source that has a start/busy/done handshake.

---
 rtl/sequence_generator_serial.sv | 129 ++++++++++++
 tb/tb_sequence_generator_serial.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sequence_generator_serial.sv
// Serial MSB-first pattern transmitter with start/busy/done handshake and repeat count.
// Optional feature macro: SEQGEN_GAP_EN adds the gap input and idle GAP state between repetitions.
module sequence_generator_serial #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
`ifdef SEQGEN_GAP_EN
  input  logic [CNT_W-1:0] gap,
`endif
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SEQGEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rep;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] first_idx;
`ifdef SEQGEN_GAP_EN
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gcnt;
`endif

  function automatic logic legal_start(input logic             s,
                                       input logic [LEN_W-1:0] l,
                                       input logic [CNT_W-1:0] r);
    return s && (l != '0) && (l <= LEN_W'(WIDTH)) && (r != '0);
  endfunction

  assign first_idx = IDX_W'(len - LEN_W'(1));
  assign last_idx  = IDX_W'(len_q - LEN_W'(1));

  // Outputs are registered together with the state, so a bit chosen on edge k is on x for the cycle after k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      idx   <= '0;
      rep   <= '0;
      x     <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQGEN_GAP_EN
      gap_q <= '0;
      gcnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (legal_start(start, len, reps)) begin
            pat_q <= pattern;
            len_q <= len;
            rep   <= reps;
            idx   <= first_idx;
`ifdef SEQGEN_GAP_EN
            gap_q <= gap;
`endif
            x     <= pattern[first_idx];
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            idx <= idx - IDX_W'(1);
            x   <= pat_q[idx - IDX_W'(1)];
          end else if (rep > CNT_W'(1)) begin
            rep <= rep - CNT_W'(1);
            idx <= last_idx;
`ifdef SEQGEN_GAP_EN
            if (gap_q != '0) begin
              gcnt  <= gap_q;
              x     <= 1'b0;
              valid <= 1'b0;
              state <= GAP;
            end else begin
              x <= pat_q[last_idx];
            end
`else
            x <= pat_q[last_idx];
`endif
          end else begin
            x     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          if (gcnt == CNT_W'(1)) begin
            x     <= pat_q[last_idx];
            valid <= 1'b1;
            state <= SHIFT;
          end else begin
            gcnt <= gcnt - CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator_serial.sv
// Randomized bench for sequence_generator_serial against a queue-based stream model.
module tb_sequence_generator_serial;
  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] reps = '0;
`ifdef SEQGEN_GAP_EN
  logic [CNT_W-1:0] gap = '0;
`endif
  logic x, valid, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sequence_generator_serial #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
`ifdef SEQGEN_GAP_EN
    .gap(gap),
`endif
    .x(x), .valid(valid), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // {x,valid,busy,done}
  task automatic check_idle(input string tag);
    check(tag, {28'd0, x, valid, busy, done}, 32'd0);
  endtask

  task automatic scramble();
    pattern = WIDTH'($urandom);
    len     = LEN_W'($urandom);
    reps    = CNT_W'($urandom);
`ifdef SEQGEN_GAP_EN
    gap     = CNT_W'($urandom);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_idle("idle");
    end
  endtask

  // Called at a negedge; returns at a negedge that has already been checked
  // (for a legal transfer that is the done cycle).
  task automatic xfer(input logic [WIDTH-1:0] p, input int l, input int r, input int g, input bit poke);
    logic [1:0] exp_q[$];
    int ge;
    bit ok;
    ok = (l >= 1) && (l <= WIDTH) && (r >= 1);
    ge = g;
`ifndef SEQGEN_GAP_EN
    ge = 0;
`endif
    start   = 1'b1;
    pattern = p;
    len     = LEN_W'(l);
    reps    = CNT_W'(r);
`ifdef SEQGEN_GAP_EN
    gap     = CNT_W'(g);
`endif
    @(negedge clk);
    start = 1'b0;
    scramble();
    if (!ok) begin
      check_idle("illegal");
      idle(2);
      return;
    end
    for (int rr = 0; rr < r; rr++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1});
      if (rr < r - 1) for (int k = 0; k < ge; k++) exp_q.push_back(2'b00);
    end
    foreach (exp_q[j]) begin
      check("stream", {28'd0, x, valid, busy, done}, {28'd0, exp_q[j], 2'b10});
      start = poke && ($urandom_range(0, 3) == 0);
      scramble();
      @(negedge clk);
    end
    start = 1'b0;
    check("done", {28'd0, x, valid, busy, done}, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    int l, r, g;
    logic [3:0] first4;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    xfer(8'h05, 3, 3, 0, 1'b0);
    idle(2);
    xfer(8'hA5, 8, 1, 0, 1'b0);
    idle(1);
    xfer(8'h05, 0, 3, 0, 1'b0);
    xfer(8'h05, 9, 3, 0, 1'b0);
    xfer(8'h05, 3, 0, 0, 1'b0);
    xfer(8'h05, 3, 3, 0, 1'b1);
    xfer(8'hA5, 8, 2, 0, 1'b0);
    idle(1);
    xfer(8'h05, 3, 2, 2, 1'b0);
    idle(1);

    // Abort after 4 bits of a 9-bit stream.
    start = 1'b1; pattern = 8'h05; len = 3; reps = 3;
    @(negedge clk);
    start = 1'b0;
    first4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      check("pre_abort", {31'd0, x}, {31'd0, first4[3-i]});
      if (i < 3) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_idle("abort_async");
    idle(3);
    rst = 1'b1;
    idle(1);
    xfer(8'h05, 3, 3, 0, 1'b0);
    idle(1);

    for (int t = 0; t < 60; t++) begin
      p = WIDTH'($urandom);
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, WIDTH));
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, ($urandom_range(0, 4) == 0) ? 15 : 4));
      g = int'($urandom_range(0, 3));
      xfer(p, l, r, g, 1'(($urandom_range(0, 1))));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
